imm_ext_arbiter: RTL and testbench



---
 rtl/imm_ext_pkg.sv | 35 +++
 rtl/imm_ext_core.sv | 26 ++
 rtl/imm_ext_arbiter.sv | 161 ++++++++++++++++
 tb/tb_imm_ext_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// Shared definitions for the time-shared immediate-extension unit:
// extension mode encodings, datapath widths, the output register state type
// and the extension helper function used by the extender core.
package imm_ext_pkg;

    localparam logic [1:0] MODE_ZE16 = 2'b00;
    localparam logic [1:0] MODE_SE16 = 2'b01;
    localparam logic [1:0] MODE_SE26 = 2'b10;
    localparam logic [1:0] MODE_ZE26 = 2'b11;

    localparam int IMM_W  = 26;
    localparam int DATA_W = 32;

    // Output register occupancy
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    // Extend a raw immediate to the datapath width. Bits above the selected
    // source width are ignored; zero-extension is unsigned.
    function automatic logic [DATA_W-1:0] imm_extend(input logic [IMM_W-1:0] imm,
                                                     input logic [1:0]       mode);
        logic [DATA_W-1:0] res;
        case (mode)
            MODE_ZE16: res = {16'b0, imm[15:0]};
            MODE_SE16: res = {{16{imm[15]}}, imm[15:0]};
            MODE_SE26: res = {{6{imm[25]}}, imm[25:0]};
            MODE_ZE26: res = {6'b0, imm[25:0]};
            default:   res = 32'h0000_0000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: 16/26-bit raw immediate to 32 bits,
// with an optional left shift by two for word-aligned offsets/targets.
module imm_ext_core
    import imm_ext_pkg::*;
(
    input  logic [IMM_W-1:0]  imm_i,
    input  logic [1:0]        mode_i,
    input  logic              shift_i,
    output logic [DATA_W-1:0] out_o
);

    logic [DATA_W-1:0] ext_s;

    assign ext_s = imm_extend(imm_i, mode_i);

    // Apply the optional shift; top two bits fall off, low two bits are zero
    always_comb begin
        out_o = ext_s;
        if (shift_i) begin
            out_o = {ext_s[DATA_W-3:0], 2'b00};
        end else begin
            out_o = ext_s;
        end
    end

endmodule

// File: rtl/imm_ext_arbiter.sv
// Shared immediate-extension unit with round-robin arbitration over NREQ
// requesters and a single registered valid/ready result port tagged with
// the requester index.
// Optional feature macro: IMM_EXT_SHIFT2_EN adds the Req_Shift port and the
// shift-left-by-two option on the extended result.
module imm_ext_arbiter
    import imm_ext_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [NREQ-1:0]       Req_Valid,
    output logic [NREQ-1:0]       Req_Ready,
    input  logic [NREQ*IMM_W-1:0] Req_Imm,
    input  logic [NREQ*2-1:0]     Req_Mode,
`ifdef IMM_EXT_SHIFT2_EN
    input  logic [NREQ-1:0]       Req_Shift,
`endif
    output logic                  Out_Valid,
    input  logic                  Out_Ready,
    output logic [DATA_W-1:0]     Out_Data,
    output logic [ID_W-1:0]       Out_Id
);

    out_state_e        state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic              free_s;
    logic              grant_found_s;
    logic              grant_s;
    logic [ID_W-1:0]   grant_idx_s;
    logic [IMM_W-1:0]  sel_imm_s;
    logic [1:0]        sel_mode_s;
    logic              sel_shift_s;
    logic [DATA_W-1:0] ext_data_s;

    // The result slot can take a new value when empty or when it drains now
    assign free_s  = (state_q == OUT_EMPTY) || Out_Ready;
    assign grant_s = free_s && grant_found_s;

    // Round-robin pick: first valid requester at or above rr_ptr, then wrap
    // to the ones below it; also selects that requester's operands.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        sel_imm_s     = '0;
        sel_mode_s    = 2'b00;
        sel_shift_s   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_found_s && Req_Valid[i] && (i >= int'(rr_ptr_q))) begin
                grant_found_s = 1'b1;
                grant_idx_s   = ID_W'(i);
                sel_imm_s     = Req_Imm[i*IMM_W +: IMM_W];
                sel_mode_s    = Req_Mode[i*2 +: 2];
`ifdef IMM_EXT_SHIFT2_EN
                sel_shift_s   = Req_Shift[i];
`else
                sel_shift_s   = 1'b0;
`endif
            end else begin
                grant_found_s = grant_found_s;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_found_s && Req_Valid[i] && (i < int'(rr_ptr_q))) begin
                grant_found_s = 1'b1;
                grant_idx_s   = ID_W'(i);
                sel_imm_s     = Req_Imm[i*IMM_W +: IMM_W];
                sel_mode_s    = Req_Mode[i*2 +: 2];
`ifdef IMM_EXT_SHIFT2_EN
                sel_shift_s   = Req_Shift[i];
`else
                sel_shift_s   = 1'b0;
`endif
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // One-hot grant, forced low while reset is held
    always_comb begin
        Req_Ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_s && Reset && (grant_idx_s == ID_W'(i))) begin
                Req_Ready[i] = 1'b1;
            end else begin
                Req_Ready[i] = 1'b0;
            end
        end
    end

    imm_ext_core u_core (
        .imm_i   (sel_imm_s),
        .mode_i  (sel_mode_s),
        .shift_i (sel_shift_s),
        .out_o   (ext_data_s)
    );

    // Output register next state: load on grant, drain, or hold while stalled
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        id_d     = id_q;
        rr_ptr_d = rr_ptr_q;
        if (grant_s) begin
            data_d = ext_data_s;
            id_d   = grant_idx_s;
            if (grant_idx_s == ID_W'(NREQ-1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx_s + ID_W'(1);
            end
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
        case (state_q)
            OUT_EMPTY: begin
                if (grant_s) begin
                    state_d = OUT_FULL;
                end else begin
                    state_d = OUT_EMPTY;
                end
            end
            OUT_FULL: begin
                if (grant_s) begin
                    state_d = OUT_FULL;
                end else if (Out_Ready) begin
                    state_d = OUT_EMPTY;
                end else begin
                    state_d = OUT_FULL;
                end
            end
            default: state_d = OUT_EMPTY;
        endcase
    end

    // State, result and round-robin pointer registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= OUT_EMPTY;
            data_q   <= 32'h0000_0000;
            id_q     <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            id_q     <= id_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign Out_Valid = (state_q == OUT_FULL);
    assign Out_Data  = data_q;
    assign Out_Id    = id_q;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Directed bench for imm_ext_arbiter: a table of single-cycle vectors
// followed by hand-written multi-cycle sequences (round-robin streaming,
// output stall, reset in flight).
module tb_imm_ext_arbiter;

    logic        Clk;
    logic        Reset;
    logic [2:0]  Req_Valid;
    logic [2:0]  Req_Ready;
    logic [77:0] Req_Imm;
    logic [5:0]  Req_Mode;
`ifdef IMM_EXT_SHIFT2_EN
    logic [2:0]  Req_Shift;
`endif
    logic        Out_Valid;
    logic        Out_Ready;
    logic [31:0] Out_Data;
    logic [1:0]  Out_Id;

    int checks = 0;
    int errors = 0;

    imm_ext_arbiter #(.NREQ(3)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Req_Valid (Req_Valid),
        .Req_Ready (Req_Ready),
        .Req_Imm   (Req_Imm),
        .Req_Mode  (Req_Mode),
`ifdef IMM_EXT_SHIFT2_EN
        .Req_Shift (Req_Shift),
`endif
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Out_Data  (Out_Data),
        .Out_Id    (Out_Id)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        logic [2:0]  valid;
        logic [25:0] imm0;
        logic [25:0] imm1;
        logic [25:0] imm2;
        logic [5:0]  mode;
        logic        out_ready;
        logic [2:0]  exp_rdy;
        logic        exp_valid;
        logic        chk_data;
        logic [31:0] exp_data;
        logic [1:0]  exp_id;
    } vec_t;

    vec_t vecs[9];

    function automatic vec_t mk(input string nm, input logic [2:0] v,
                                input logic [25:0] i0, input logic [25:0] i1,
                                input logic [25:0] i2, input logic [5:0] m,
                                input logic ordy, input logic [2:0] erdy,
                                input logic ev, input logic cd,
                                input logic [31:0] ed, input logic [1:0] eid);
        vec_t r;
        r.name = nm; r.valid = v; r.imm0 = i0; r.imm1 = i1; r.imm2 = i2;
        r.mode = m; r.out_ready = ordy; r.exp_rdy = erdy; r.exp_valid = ev;
        r.chk_data = cd; r.exp_data = ed; r.exp_id = eid;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    initial begin
        logic [2:0] erdy;
        logic [1:0] eid;

        // modes: {req2, req1, req0}; 00 ZE16, 01 SE16, 10 SE26, 11 ZE26
        vecs[0] = mk("idle",      3'b000, 26'h0, 26'h0, 26'h0, 6'b000000, 1'b1,
                     3'b000, 1'b0, 1'b1, 32'h0000_0000, 2'd0);
        vecs[1] = mk("r0_se16",   3'b001, 26'h2AA8001, 26'h0, 26'h0, 6'b000001, 1'b1,
                     3'b001, 1'b1, 1'b1, 32'hFFFF_8001, 2'd0);
        vecs[2] = mk("r2_se26",   3'b100, 26'h0, 26'h0, 26'h2000004, 6'b100000, 1'b1,
                     3'b100, 1'b1, 1'b1, 32'hFE00_0004, 2'd2);
        vecs[3] = mk("r1_ze16",   3'b010, 26'h0, 26'h3FF8001, 26'h0, 6'b000000, 1'b1,
                     3'b010, 1'b1, 1'b1, 32'h0000_8001, 2'd1);
        vecs[4] = mk("r0_ze26",   3'b001, 26'h3FFFFFF, 26'h0, 26'h0, 6'b000011, 1'b1,
                     3'b001, 1'b1, 1'b1, 32'h03FF_FFFF, 2'd0);
        vecs[5] = mk("rr_skip0",  3'b101, 26'h0, 26'h0, 26'h0001234, 6'b000000, 1'b1,
                     3'b100, 1'b1, 1'b1, 32'h0000_1234, 2'd2);
        vecs[6] = mk("rr_wrap1",  3'b110, 26'h0, 26'h0007FFF, 26'h0, 6'b000100, 1'b1,
                     3'b010, 1'b1, 1'b1, 32'h0000_7FFF, 2'd1);
        vecs[7] = mk("rr_wrap0",  3'b011, 26'h1FFFFFF, 26'h0, 26'h0, 6'b000010, 1'b1,
                     3'b001, 1'b1, 1'b1, 32'h01FF_FFFF, 2'd0);
        vecs[8] = mk("drain",     3'b000, 26'h0, 26'h0, 26'h0, 6'b000000, 1'b1,
                     3'b000, 1'b0, 1'b0, 32'h0000_0000, 2'd0);

        Reset = 1'b0; Req_Valid = 3'b000; Req_Imm = '0; Req_Mode = 6'b000000;
        Out_Ready = 1'b1;
`ifdef IMM_EXT_SHIFT2_EN
        Req_Shift = 3'b000;
`endif
        @(posedge Clk); #1;
        Req_Valid = 3'b111;
        #1 chk("rdy_in_reset", {29'h0, Req_Ready}, 32'h0);
        Req_Valid = 3'b000;
        @(posedge Clk); #1;
        Reset = 1'b1;

        // table-driven single-cycle vectors
        for (int v = 0; v < 9; v++) begin
            Req_Valid = vecs[v].valid;
            Req_Imm   = {vecs[v].imm2, vecs[v].imm1, vecs[v].imm0};
            Req_Mode  = vecs[v].mode;
            Out_Ready = vecs[v].out_ready;
            #1 chk({vecs[v].name, "_rdy"}, {29'h0, Req_Ready}, {29'h0, vecs[v].exp_rdy});
            @(posedge Clk); #1;
            chk({vecs[v].name, "_valid"}, {31'h0, Out_Valid}, {31'h0, vecs[v].exp_valid});
            if (vecs[v].chk_data) begin
                chk({vecs[v].name, "_data"}, Out_Data, vecs[v].exp_data);
                chk({vecs[v].name, "_id"}, {30'h0, Out_Id}, {30'h0, vecs[v].exp_id});
            end else begin
                checks = checks;
            end
        end

`ifdef IMM_EXT_SHIFT2_EN
        // rr_ptr is 1 here; requester 2 with shift
        Req_Valid = 3'b100; Req_Imm = {26'h2000004, 26'h0, 26'h0};
        Req_Mode = 6'b100000; Req_Shift = 3'b100;
        #1 chk("shift_rdy", {29'h0, Req_Ready}, 32'h4);
        @(posedge Clk); #1;
        chk("shift_data", Out_Data, 32'hF800_0010);
        Req_Shift = 3'b000; Req_Valid = 3'b000;
`endif

        // reset pulse so the pointer restarts at 0
        Reset = 1'b0;
        #1 chk("rst_pulse_valid", {31'h0, Out_Valid}, 32'h0);
        @(posedge Clk); #1;
        Reset = 1'b1;

        // all requesters valid every cycle: 0,1,2,0,1,2
        Req_Valid = 3'b111;
        Req_Imm   = {26'h0000033, 26'h0000022, 26'h0000011};
        Req_Mode  = 6'b000000;
        Out_Ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            eid  = 2'(c % 3);
            erdy = 3'b001 << eid;
            #1 chk("rr_rdy", {29'h0, Req_Ready}, {29'h0, erdy});
            @(posedge Clk); #1;
            chk("rr_valid", {31'h0, Out_Valid}, 32'h1);
            chk("rr_id", {30'h0, Out_Id}, {30'h0, eid});
            chk("rr_data", Out_Data, 32'h11 * (32'(eid) + 32'h1));
        end

        // stall: output full, consumer not ready for 4 cycles
        Out_Ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1 chk("stall_rdy", {29'h0, Req_Ready}, 32'h0);
            @(posedge Clk); #1;
            chk("stall_valid", {31'h0, Out_Valid}, 32'h1);
            chk("stall_id", {30'h0, Out_Id}, 32'h2);
            chk("stall_data", Out_Data, 32'h0000_0033);
        end
        // drain and refill in the same cycle
        Out_Ready = 1'b1;
        #1 chk("refill_rdy", {29'h0, Req_Ready}, 32'h1);
        @(posedge Clk); #1;
        chk("refill_valid", {31'h0, Out_Valid}, 32'h1);
        chk("refill_id", {30'h0, Out_Id}, 32'h0);
        chk("refill_data", Out_Data, 32'h0000_0011);

        // reset while a result is pending
        Out_Ready = 1'b0;
        Reset = 1'b0;
        #1 chk("midrst_valid", {31'h0, Out_Valid}, 32'h0);
        chk("midrst_rdy", {29'h0, Req_Ready}, 32'h0);
        @(posedge Clk); #1;
        Req_Valid = 3'b110;
        Reset = 1'b1;
        #1 chk("postrst_rdy", {29'h0, Req_Ready}, 32'h2);
        Out_Ready = 1'b1;
        @(posedge Clk); #1;
        chk("postrst_valid", {31'h0, Out_Valid}, 32'h1);
        chk("postrst_id", {30'h0, Out_Id}, 32'h1);
        chk("postrst_data", Out_Data, 32'h0000_0022);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
